// File: rtl/barrel_pkg.sv
// Shared opcodes and elaboration helpers for the pipelined barrel rotator.
package barrel_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ROL  = 3'b001;
    localparam logic [2:0] OP_ROR  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_SRL  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One log2 step of the barrel network: moves data by DIST positions when en is set.
module shift_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        if (en) begin
            case (op)
                OP_ROL:  result = {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
                OP_ROR:  result = {data[DIST-1:0], data[WIDTH-1:DIST]};
                OP_SLL:  result = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                OP_SRL:  result = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
                OP_SRA:  result = {{DIST{data[WIDTH-1]}}, data[WIDTH-1:DIST]};
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/barrel_rotator_pipe.sv
// Pipelined barrel shifter/rotator with per-stage or single output register
// and a valid/ready handshake that stalls the whole pipe under backpressure.
module barrel_rotator_pipe
    import barrel_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  PIPE  = 1,
    localparam int SW    = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             out_zero
);

    logic             adv;
    logic             acc;
    logic             in_err;
    logic [WIDTH-1:0] in_data_m;
    logic             fin_valid;
    logic             fin_err;
    logic [WIDTH-1:0] fin_data;

    assign adv      = !fin_valid || out_ready;
    assign in_ready = adv;
    assign acc      = in_valid && adv;
    assign in_err   = in_op[2] && in_op[1];
    // Illegal ops enter as zero; every stage leaves zero untouched.
    assign in_data_m = in_err ? '0 : in_data;

    for (genvar k = 0; k < SW; k++) begin : g_st
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] mv;
        logic             en;
        logic [2:0]       op;

        if (k == 0) begin : g_src
            assign src = in_data_m;
            assign en  = in_amt[0];
            assign op  = in_op;
        end else if (PIPE != 0) begin : g_src
            assign src = g_st[k-1].g_reg.r_data;
            assign en  = g_st[k-1].g_reg.g_ctl.r_amt[k];
            assign op  = g_st[k-1].g_reg.g_ctl.r_op;
        end else begin : g_src
            assign src = g_st[k-1].mv;
            assign en  = in_amt[k];
            assign op  = in_op;
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data   (src),
            .en     (en),
            .op     (op),
            .result (mv)
        );

        if (PIPE != 0) begin : g_reg
            logic             r_valid;
            logic             r_err;
            logic [WIDTH-1:0] r_data;
            logic             v_in;
            logic             e_in;

            if (k == 0) begin : g_ve
                assign v_in = acc;
                assign e_in = in_err;
            end else begin : g_ve
                assign v_in = g_st[k-1].g_reg.r_valid;
                assign e_in = g_st[k-1].g_reg.r_err;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    r_data  <= '0;
                end else if (adv) begin
                    r_valid <= v_in;
                    r_err   <= e_in;
                    r_data  <= mv;
                end
            end

            // Only the amount bits still to be applied travel onward; the
            // last stage needs neither amount nor opcode.
            if (k < SW - 1) begin : g_ctl
                logic [SW-1:k+1] r_amt;
                logic [2:0]      r_op;
                logic [SW-1:k+1] a_in;

                if (k == 0) begin : g_a
                    assign a_in = in_amt[SW-1:1];
                end else begin : g_a
                    assign a_in = g_st[k-1].g_reg.g_ctl.r_amt[SW-1:k+1];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_amt <= '0;
                        r_op  <= '0;
                    end else if (adv) begin
                        r_amt <= a_in;
                        r_op  <= op;
                    end
                end
            end
        end
    end

    if (PIPE != 0) begin : g_out
        assign fin_valid = g_st[SW-1].g_reg.r_valid;
        assign fin_err   = g_st[SW-1].g_reg.r_err;
        assign fin_data  = g_st[SW-1].g_reg.r_data;
    end else begin : g_out
        logic             r_valid;
        logic             r_err;
        logic [WIDTH-1:0] r_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                r_data  <= '0;
            end else if (adv) begin
                r_valid <= acc;
                r_err   <= in_err;
                r_data  <= g_st[SW-1].mv;
            end
        end

        assign fin_valid = r_valid;
        assign fin_err   = r_err;
        assign fin_data  = r_data;
    end

    assign out_valid = fin_valid;
    assign out_data  = fin_data;
    assign out_err   = fin_valid && fin_err;
    assign out_zero  = fin_valid && (fin_data == '0);

endmodule

// File: tb/tb_barrel_rotator_pipe.sv
// Scoreboard bench: an 8-bit per-stage-pipelined instance and a 16-bit single-register instance.
module tb_barrel_rotator_pipe;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        zero;
        int unsigned tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        v8, r8, or8, ov8, oe8, oz8;
    logic [7:0]  d8, od8;
    logic [2:0]  a8, op8;
    logic        v16, r16, or16, ov16, oe16, oz16;
    logic [15:0] d16, od16;
    logic [3:0]  a16;
    logic [2:0]  op16;

    exp_t        q8[$];
    exp_t        q16[$];
    int unsigned adv_cnt [2] = '{0, 0};
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rnd_rdy = 1'b0;
    bit          held [2] = '{1'b0, 1'b0};
    logic [17:0] held_val [2];

    barrel_rotator_pipe #(.WIDTH(8), .PIPE(1)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_data(d8), .in_amt(a8),
        .in_op(op8), .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_err(oe8), .out_zero(oz8)
    );

    barrel_rotator_pipe #(.WIDTH(16), .PIPE(0)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_data(d16), .in_amt(a16),
        .in_op(op16), .out_valid(ov16), .out_ready(or16), .out_data(od16), .out_err(oe16), .out_zero(oz16)
    );

    always #5 clk = ~clk;

    // Advancing edges: latency is measured in these, so stalls do not count.
    always @(posedge clk) begin
        if (r8)  adv_cnt[0]++;
        if (r16) adv_cnt[1]++;
    end

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d) at %0t: got %h, expected %h", name, k, $time, act, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [15:0] x, input int a, input int op);
        exp_t            e;
        longint unsigned m, v, r;
        m = (64'd1 << w) - 1;
        v = {48'd0, x} & m;
        r = 0;
        e.err = 1'b0;
        case (op)
            0: r = v;
            1: for (int i = 0; i < w; i++) r[i] = v[(i - a + w) % w];
            2: for (int i = 0; i < w; i++) r[i] = v[(i + a) % w];
            3: r = (v * (64'd1 << a)) % (m + 1);
            4: r = v / (64'd1 << a);
            5: begin
                r = v / (64'd1 << a);
                if (v[w-1]) r = r | (m & ~(m >> a));
            end
            default: begin
                r = 0;
                e.err = 1'b1;
            end
        endcase
        e.data = r[15:0];
        e.zero = (r == 0);
        e.tag  = 0;
        return e;
    endfunction

    task automatic mon(input int k);
        logic        ov, ordy, irdy, oe, oz;
        logic [15:0] od;
        exp_t        e;
        int          qs;
        if (k == 0) begin
            ov = ov8; ordy = or8; irdy = r8; oe = oe8; oz = oz8; od = {8'h00, od8}; qs = q8.size();
        end else begin
            ov = ov16; ordy = or16; irdy = r16; oe = oe16; oz = oz16; od = od16; qs = q16.size();
        end
        chk(k, "in_ready", {31'd0, irdy}, {31'd0, !ov || ordy});
        if (held[k]) chk(k, "stall_hold", {14'd0, oe, oz, od}, {14'd0, held_val[k]});
        if (ov) begin
            if (qs == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result (dut%0d) at %0t: got %h, expected none", k, $time, od);
            end else begin
                if (k == 0) e = q8[0]; else e = q16[0];
                chk(k, "data", {16'd0, od}, {16'd0, e.data});
                chk(k, "err", {31'd0, oe}, {31'd0, e.err});
                chk(k, "zero", {31'd0, oz}, {31'd0, e.zero});
                chk(k, "latency", adv_cnt[k], e.tag);
                if (ordy) begin
                    if (k == 0) void'(q8.pop_front()); else void'(q16.pop_front());
                end
            end
        end
        held[k]     = ov && !ordy;
        held_val[k] = {oe, oz, od};
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held[0] = 1'b0;
            held[1] = 1'b0;
        end else begin
            mon(0);
            mon(1);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) begin
            or8  = ($urandom_range(0, 9) < 7);
            or16 = ($urandom_range(0, 9) < 7);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic send(input bit w, input logic [15:0] d, input int a, input int op);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        if (w) begin
            v16 = 1'b1; d16 = d; a16 = 4'(a); op16 = 3'(op);
        end else begin
            v8 = 1'b1; d8 = d[7:0]; a8 = 3'(a); op8 = 3'(op);
        end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (w ? r16 : r8) begin
                ok = 1'b1;
                e = model(w ? 16 : 8, d, a, op);
                e.tag = adv_cnt[w] + (w ? 1 : 3);
                if (w) q16.push_back(e); else q8.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout (dut%0d): got no in_ready, expected acceptance", w);
        end
    endtask

    task automatic idle(input bit w);
        if (w) v16 = 1'b0; else v8 = 1'b0;
    endtask

    task automatic drain(input bit w);
        for (int i = 0; i < 300 && (w ? q16.size() : q8.size()) != 0; i++) @(posedge clk);
        chk(w, "drain_left", w ? q16.size() : q8.size(), 0);
        #1;
    endtask

    initial begin
        v8 = 1'b0; d8 = '0; a8 = '0; op8 = '0; or8 = 1'b1;
        v16 = 1'b0; d16 = '0; a16 = '0; op16 = '0; or16 = 1'b1;
        #12;
        chk(0, "rst_valid", {31'd0, ov8}, 0);
        chk(0, "rst_data", {24'd0, od8}, 0);
        chk(0, "rst_err", {31'd0, oe8}, 0);
        chk(0, "rst_zero", {31'd0, oz8}, 0);
        chk(0, "rst_in_ready", {31'd0, r8}, 1);
        chk(1, "rst_valid", {31'd0, ov16}, 0);
        chk(1, "rst_data", {16'd0, od16}, 0);
        chk(1, "rst_in_ready", {31'd0, r16}, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(0, 16'h0081, 1, 1);
        send(0, 16'h0001, 3, 2);
        send(0, 16'h00FF, 4, 3);
        send(0, 16'h0080, 7, 4);
        send(0, 16'h0080, 7, 5);
        send(0, 16'h0040, 6, 5);
        send(0, 16'h00AA, 0, 6);
        send(0, 16'h0000, 0, 0);
        send(0, 16'h0055, 0, 7);
        idle(0);
        drain(0);

        fork
            begin
                for (int i = 1; i <= 5; i++) send(0, 16'(i * 17), 0, 0);
                idle(0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                or8 = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                or8 = 1'b1;
            end
        join
        drain(0);

        send(0, 16'h0012, 1, 1);
        send(0, 16'h0034, 2, 2);
        send(0, 16'h0056, 3, 3);
        idle(0);
        #2;
        rst = 1'b1;
        q8.delete();
        q16.delete();
        #1;
        chk(0, "midrst_valid", {31'd0, ov8}, 0);
        chk(0, "midrst_data", {24'd0, od8}, 0);
        chk(0, "midrst_in_ready", {31'd0, r8}, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(0, 16'h005A, 3, 2);
        idle(0);
        drain(0);

        rnd_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            send(0, 16'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                idle(0);
                @(posedge clk);
                #1;
            end
        end
        idle(0);
        rnd_rdy = 1'b0;
        or8 = 1'b1;
        or16 = 1'b1;
        drain(0);

        send(1, 16'h8001, 15, 1);
        send(1, 16'h8000, 15, 5);
        send(1, 16'h1234, 0, 2);
        send(1, 16'hBEEF, 3, 7);
        idle(1);
        drain(1);

        rnd_rdy = 1'b1;
        for (int n = 0; n < 100; n++) begin
            send(1, 16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
                @(posedge clk);
                #1;
            end
        end
        idle(1);
        rnd_rdy = 1'b0;
        or8 = 1'b1;
        or16 = 1'b1;
        drain(1);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
